// File: rtl/nios_system_cpu_1_oci_pkg.sv
// Shared OCI trace package: DCT geometry constants,
// controller state encoding and the packed buffer type.
package nios_system_cpu_1_oci_pkg;

  localparam int SLOT_W = 2;
  localparam int NSLOTS = 15;
  localparam int LEN_W  = 3;
  localparam int CNT_W  = 4;
  localparam int REC_W  = 16;
  localparam int BUF_W  = SLOT_W * NSLOTS;

  typedef enum logic [1:0] {
    ACCUM      = 2'd0,
    EMIT       = 2'd1,
    FLUSH_EMIT = 2'd2,
    DONE       = 2'd3
  } dct_state_e;

  typedef logic [BUF_W-1:0] dct_buf_t;

endpackage

// File: rtl/nios_system_cpu_1_oci_dct_pack.sv
// DCT record packer (combinational).
// Ports: buf_i/cnt_i current buffer, len_i/data_i record; buf_o/cnt_o next, fit_o record fits.
module nios_system_cpu_1_oci_dct_pack
  import nios_system_cpu_1_oci_pkg::*;
(
  input  logic [BUF_W-1:0] buf_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [REC_W-1:0] data_i,
  output logic [BUF_W-1:0] buf_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             fit_o
);

  logic [CNT_W:0]   slots_w;
  logic [CNT_W:0]   sum_w;
  logic [REC_W-1:0] rec_w;

  assign slots_w = (CNT_W+1)'(len_i) + (CNT_W+1)'(1);
  assign sum_w   = {1'b0, cnt_i} + slots_w;
  assign fit_o   = sum_w <= (CNT_W+1)'(NSLOTS);

  // slots above len are don't-care on the input
  assign rec_w = data_i & ~({REC_W{1'b1}} << {slots_w, 1'b0});

  // only used when fit_o, so nothing is shifted past the top
  assign buf_o = buf_i | (BUF_W'(rec_w) << {cnt_i, 1'b0});
  assign cnt_o = sum_w[CNT_W-1:0];

endmodule

// File: rtl/nios_system_cpu_1_oci_dct_ctrl.sv
// DCT controller: round-robin packs i/d trace records, emits frames, handles test-end flush.
// Ports: i_*/d_* record req/ack, test_ending/test_has_ended, dct_* buffer view, frm_* frame port.
module nios_system_cpu_1_oci_dct_ctrl
  import nios_system_cpu_1_oci_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [2:0]  i_len,
  input  logic [15:0] i_data,
  output logic        i_ack,
  input  logic        d_req,
  input  logic [2:0]  d_len,
  input  logic [15:0] d_data,
  output logic        d_ack,
  input  logic        test_ending,
  output logic        test_has_ended,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        frm_valid,
  input  logic        frm_ready,
  output logic [29:0] frm_data,
  output logic [3:0]  frm_count,
  output logic [15:0] frm_total
);

  dct_state_e       state_q, state_d;
  dct_buf_t         buf_q, buf_d, pk_buf_w;
  logic [CNT_W-1:0] cnt_q, cnt_d, pk_cnt_w;
  logic [15:0]      tot_q, tot_d;
  logic             rr_q, rr_d;
  logic             sel_d_w, any_w, fit_w, grant_w;
  logic [LEN_W-1:0] len_w;
  logic [REC_W-1:0] data_w;

  // rr_q=1 favours the data source; a lone requester always wins
  assign sel_d_w = d_req & (rr_q | ~i_req);
  assign any_w   = i_req | d_req;
  assign len_w   = sel_d_w ? d_len  : i_len;
  assign data_w  = sel_d_w ? d_data : i_data;

  nios_system_cpu_1_oci_dct_pack u_pack (
    .buf_i  (buf_q),
    .cnt_i  (cnt_q),
    .len_i  (len_w),
    .data_i (data_w),
    .buf_o  (pk_buf_w),
    .cnt_o  (pk_cnt_w),
    .fit_o  (fit_w)
  );

  assign grant_w = (state_q == ACCUM) & any_w & fit_w;
  assign i_ack   = grant_w & ~sel_d_w;
  assign d_ack   = grant_w & sel_d_w;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tot_d   = tot_q;
    rr_d    = rr_q;
    unique case (state_q)
      ACCUM: begin
        if (grant_w) begin
          buf_d = pk_buf_w;
          cnt_d = pk_cnt_w;
          rr_d  = ~sel_d_w;
          if (pk_cnt_w == CNT_W'(NSLOTS))
            state_d = EMIT;
        end else if (test_ending) begin
          state_d = (cnt_q != '0) ? FLUSH_EMIT : DONE;
        end else if (any_w) begin
          // pending record does not fit: ship what we have
          state_d = EMIT;
        end
      end
      EMIT, FLUSH_EMIT: begin
        if (frm_ready) begin
          buf_d   = '0;
          cnt_d   = '0;
          tot_d   = (tot_q == 16'hFFFF) ? tot_q : tot_q + 16'd1;
          state_d = (state_q == EMIT) ? ACCUM : DONE;
        end
      end
      DONE: ;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      buf_q   <= '0;
      cnt_q   <= '0;
      tot_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      tot_q   <= tot_d;
      rr_q    <= rr_d;
    end
  end

  assign frm_valid      = (state_q == EMIT) | (state_q == FLUSH_EMIT);
  assign frm_data       = frm_valid ? buf_q : '0;
  assign frm_count      = frm_valid ? cnt_q : '0;
  assign frm_total      = tot_q;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = (state_q == DONE);

endmodule

// File: tb/tb_nios_system_cpu_1_oci_dct_ctrl.sv
// Bench for the DCT controller: vector table, corner sequences
// and random traffic against a slot-queue reference model.
module tb_nios_system_cpu_1_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, test_ending, frm_ready;
  logic [2:0]  i_len, d_len;
  logic [15:0] i_data, d_data;
  logic        i_ack, d_ack, test_has_ended, frm_valid;
  logic [29:0] dct_buffer, frm_data;
  logic [3:0]  dct_count, frm_count;
  logic [15:0] frm_total;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_system_cpu_1_oci_dct_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .i_req          (i_req),
    .i_len          (i_len),
    .i_data         (i_data),
    .i_ack          (i_ack),
    .d_req          (d_req),
    .d_len          (d_len),
    .d_data         (d_data),
    .d_ack          (d_ack),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .frm_valid      (frm_valid),
    .frm_ready      (frm_ready),
    .frm_data       (frm_data),
    .frm_count      (frm_count),
    .frm_total      (frm_total)
  );

  // reference model: buffer as a queue of 2-bit slots
  // mode 0 collecting, 1 frame out, 2 final frame out, 3 finished
  logic [1:0] m_q[$];
  int         m_mode = 0;
  bit         m_pref_d = 0;
  int         m_total = 0;
  bit         last_i, last_d;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_buf();
    logic [31:0] b = 0;
    foreach (m_q[k]) b |= 32'(m_q[k]) << (2 * k);
    return b;
  endfunction

  function automatic void m_acks(output bit ia, output bit da);
    bit pick_d;
    int len;
    ia = 0;
    da = 0;
    if (m_mode != 0) return;
    if (!i_req && !d_req) return;
    if (!d_req) pick_d = 0;
    else if (!i_req) pick_d = 1;
    else pick_d = m_pref_d;
    len = pick_d ? int'(d_len) : int'(i_len);
    if (m_q.size() + len + 1 > 15) return;
    if (pick_d) da = 1;
    else ia = 1;
  endfunction

  task automatic m_clear();
    m_q.delete();
    m_mode = 0;
    m_pref_d = 0;
    m_total = 0;
  endtask

  task automatic m_step(bit ia, bit da);
    if (reset) begin
      m_clear();
      return;
    end
    case (m_mode)
      0: begin
        if (ia || da) begin
          logic [15:0] dat = ia ? i_data : d_data;
          int n = (ia ? int'(i_len) : int'(d_len)) + 1;
          for (int k = 0; k < n; k++) m_q.push_back(dat[2*k +: 2]);
          m_pref_d = ia;
          if (m_q.size() == 15) m_mode = 1;
        end else if (test_ending) begin
          m_mode = (m_q.size() > 0) ? 2 : 3;
        end else if (i_req || d_req) begin
          m_mode = 1;
        end
      end
      1, 2: begin
        if (frm_ready) begin
          if (m_total < 65535) m_total++;
          m_q.delete();
          m_mode = (m_mode == 1) ? 0 : 3;
        end
      end
      default: ;
    endcase
  endtask

  // inputs are set at edge+1; compare at edge+3, then advance model and clock
  task automatic cycle();
    bit ia, da, fv;
    logic [31:0] eb;
    #2;
    m_acks(ia, da);
    eb = m_buf();
    fv = (m_mode == 1) || (m_mode == 2);
    last_i = i_ack;
    last_d = d_ack;
    chk("i_ack", 32'(i_ack), 32'(ia));
    chk("d_ack", 32'(d_ack), 32'(da));
    chk("dct_count", 32'(dct_count), m_q.size());
    chk("dct_buffer", 32'(dct_buffer), eb);
    chk("frm_valid", 32'(frm_valid), 32'(fv));
    chk("frm_data", 32'(frm_data), fv ? eb : 0);
    chk("frm_count", 32'(frm_count), fv ? m_q.size() : 0);
    chk("frm_total", 32'(frm_total), m_total);
    chk("test_has_ended", 32'(test_has_ended), 32'(m_mode == 3));
    m_step(ia, da);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_clear();
    last_i = 0;
    last_d = 0;
  endtask

  typedef struct {
    bit          req;
    logic [2:0]  len;
    logic [15:0] data;
    bit          exp_ack;
    logic [3:0]  exp_cnt;
    bit          exp_fv;
  } vec_t;

  vec_t tv[6];

  initial begin
    tv[0] = '{1, 3'd2, 16'hFF39, 1, 4'd3, 0};
    tv[1] = '{1, 3'd2, 16'hC039, 1, 4'd6, 0};
    tv[2] = '{1, 3'd2, 16'h0039, 1, 4'd9, 0};
    tv[3] = '{1, 3'd2, 16'h1239, 1, 4'd12, 0};
    tv[4] = '{1, 3'd2, 16'hFFF9, 1, 4'd15, 1};
    tv[5] = '{0, 3'd0, 16'h0000, 0, 4'd15, 1};

    i_req = 0; d_req = 0; i_len = 0; d_len = 0;
    i_data = 0; d_data = 0; test_ending = 0; frm_ready = 0;
    do_reset();

    // reset state
    chk("rst_count", 32'(dct_count), 0);
    chk("rst_buffer", 32'(dct_buffer), 0);
    chk("rst_frm_valid", 32'(frm_valid), 0);
    chk("rst_frm_total", 32'(frm_total), 0);
    chk("rst_ended", 32'(test_has_ended), 0);

    // single source, five 3-slot records fill the buffer
    for (int v = 0; v < 6; v++) begin
      i_req = tv[v].req;
      i_len = tv[v].len;
      i_data = tv[v].data;
      cycle();
      chk("t1_ack", 32'(last_i), 32'(tv[v].exp_ack));
      chk("t1_cnt", 32'(dct_count), 32'(tv[v].exp_cnt));
      chk("t1_fv", 32'(frm_valid), 32'(tv[v].exp_fv));
    end
    chk("t1_frm_data", 32'(frm_data), 32'h39E79E79);
    chk("t1_frm_count", 32'(frm_count), 15);
    frm_ready = 1;
    cycle();
    frm_ready = 0;
    chk("t1_clr_cnt", 32'(dct_count), 0);
    chk("t1_total", 32'(frm_total), 1);
    chk("t1_fv_off", 32'(frm_valid), 0);

    // round robin, both held
    do_reset();
    i_req = 1; d_req = 1; i_len = 0; d_len = 0;
    i_data = 16'h0001; d_data = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t2_grant", 32'({last_i, last_d}), (k % 2 == 0) ? 32'h2 : 32'h1);
    end
    d_req = 0;
    chk("t2_buffer", 32'(dct_buffer), 32'h99);
    chk("t2_count", 32'(dct_count), 4);

    // misfit at 12, then backpressure
    i_len = 7; i_data = 16'hAAAA;
    cycle();
    chk("t3_ack8", 32'(last_i), 1);
    chk("t3_cnt12", 32'(dct_count), 12);
    i_data = 16'h5555;
    cycle();
    chk("t3_misfit_ack", 32'(last_i), 0);
    chk("t3_emit", 32'(frm_valid), 1);
    chk("t3_frm_count", 32'(frm_count), 12);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("t4_no_ack", 32'(last_i), 0);
      chk("t4_data", 32'(frm_data), 32'hAAAA99);
      chk("t4_count", 32'(frm_count), 12);
      chk("t4_total", 32'(frm_total), 0);
    end
    frm_ready = 1;
    cycle();
    frm_ready = 0;
    chk("t3_clr", 32'(dct_count), 0);
    chk("t3_total", 32'(frm_total), 1);
    cycle();
    chk("t3_late_ack", 32'(last_i), 1);
    chk("t3_cnt8", 32'(dct_count), 8);
    chk("t3_buf", 32'(dct_buffer), 32'h5555);

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (last_i || !i_req) begin
        i_req = ($urandom_range(0, 2) != 0);
        i_len = 3'($urandom);
        i_data = 16'($urandom);
      end
      if (last_d || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_len = 3'($urandom);
        d_data = 16'($urandom);
      end
      frm_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // flush with partial buffer
    i_req = 0; d_req = 0; frm_ready = 0;
    do_reset();
    i_req = 1; i_len = 4; i_data = 16'h03FF;
    cycle();
    i_req = 0;
    chk("t5_cnt5", 32'(dct_count), 5);
    test_ending = 1;
    cycle();
    chk("t5_flush_fv", 32'(frm_valid), 1);
    chk("t5_flush_cnt", 32'(frm_count), 5);
    frm_ready = 1;
    cycle();
    chk("t5_ended", 32'(test_has_ended), 1);
    chk("t5_fv_off", 32'(frm_valid), 0);
    chk("t5_total", 32'(frm_total), 1);
    i_req = 1; i_len = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t5_no_ack", 32'(last_i), 0);
    end
    chk("t5_still_ended", 32'(test_has_ended), 1);

    // flush with empty buffer
    i_req = 0; frm_ready = 0;
    do_reset();
    cycle();
    chk("t5_empty_ended", 32'(test_has_ended), 1);
    chk("t5_empty_fv", 32'(frm_valid), 0);
    chk("t5_empty_total", 32'(frm_total), 0);
    test_ending = 0;

    // reset during a frame
    do_reset();
    i_req = 1; i_len = 7; i_data = 16'hFFFF;
    cycle();
    cycle();
    chk("t6_emit", 32'(frm_valid), 1);
    i_req = 0;
    reset = 1;
    cycle();
    reset = 0;
    chk("t6_fv", 32'(frm_valid), 0);
    chk("t6_cnt", 32'(dct_count), 0);
    chk("t6_buf", 32'(dct_buffer), 0);
    i_req = 1; d_req = 1; i_len = 0; d_len = 0;
    cycle();
    chk("t6_rr", 32'({last_i, last_d}), 32'h2);
    i_req = 0; d_req = 0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
